dcache_responder: RTL and testbench

Data-cache responder serving the memory stage's load/store requests. Sits between the memory stage (the requester raising `data_missed1` and consuming `data_ready1`/`data_response1`) and the backing main-memory port. Direct-mapped, write-through, no-write-allocate cache with 4-word lines. On a miss, a fill state machine fetches the line over a request/grant/beat handshake.

---
 rtl/dcache_responder.sv | 176 +++++++++++++++++
 tb/tb_dcache_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Optional hit/miss statistics are built when DCACHE_STATS_EN is defined.
module dcache_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              data_ready,
  output logic [DATA_W-1:0] data_response,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [2:0]        state_dbg
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL_REQ  = 3'd1,
    FILL_DATA = 3'd2,
    WRITE     = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;

  logic [LINES-1:0] line_valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES][4];
  logic [DATA_W-1:0] fill_buf [4];

  logic [1:0]       beat_cnt;
  logic [1:0]       off_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;

  logic              lookup_hit;
  logic              accept_load;
  logic              accept_store;
  logic              fill_beat;
  logic              last_beat;
  logic [DATA_W-1:0] fill_word;
  logic              unused_addr_bits;

  assign req_off = req_addr[3:2];
  assign req_idx = req_addr[IDX_W+3:4];
  assign req_tag = req_addr[ADDR_W-1:IDX_W+4];
  assign unused_addr_bits = ^req_addr[1:0];

  assign lookup_hit   = line_valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept_load  = (state == IDLE) && req_valid && !req_write;
  assign accept_store = (state == IDLE) && req_valid && req_write;
  assign fill_beat    = (state == FILL_DATA) && mem_rvalid;
  assign last_beat    = fill_beat && (beat_cnt == 2'd3);
  // The requested word may be the one arriving on this very beat.
  assign fill_word    = (off_q == beat_cnt) ? mem_rdata : fill_buf[off_q];
  assign state_dbg    = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshakes: the requester holds req_valid until the one-cycle data_ready
  // pulse; mem_req is held until a cycle with mem_gnt, which completes it.
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    busy       = (state != IDLE);
    data_ready = 1'b0;
    case (state)
      IDLE: begin
        if (accept_load)       state_nxt = lookup_hit ? RESPOND : FILL_REQ;
        else if (accept_store) state_nxt = WRITE;
      end
      FILL_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = FILL_DATA;
      end
      FILL_DATA: begin
        if (last_beat) state_nxt = RESPOND;
      end
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt) state_nxt = RESPOND;
      end
      RESPOND: begin
        data_ready = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_valid    <= '0;
      beat_cnt      <= '0;
      off_q         <= '0;
      idx_q         <= '0;
      tag_q         <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      data_response <= '0;
    end else begin
      if (accept_load) begin
        off_q    <= req_off;
        idx_q    <= req_idx;
        tag_q    <= req_tag;
        beat_cnt <= '0;
        mem_addr <= {req_addr[ADDR_W-1:4], 4'b0000};
        if (lookup_hit) data_response <= data_mem[req_idx][req_off];
      end
      if (accept_store) begin
        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= req_wdata;
      end
      if (fill_beat) beat_cnt <= beat_cnt + 2'd1;
      if (last_beat) begin
        line_valid[idx_q] <= 1'b1;
        data_response     <= fill_word;
      end
      if ((state == WRITE) && mem_gnt) data_response <= mem_wdata;
    end
  end

  // Line storage carries no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (fill_beat) fill_buf[beat_cnt] <= mem_rdata;
    if (last_beat) begin
      tag_mem[idx_q]     <= tag_q;
      data_mem[idx_q][0] <= fill_buf[0];
      data_mem[idx_q][1] <= fill_buf[1];
      data_mem[idx_q][2] <= fill_buf[2];
      data_mem[idx_q][3] <= mem_rdata;
    end
    if (accept_store && lookup_hit) data_mem[req_idx][req_off] <= req_wdata;
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept_load) begin
      if (lookup_hit) hit_count  <= hit_count + 32'd1;
      else            miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: table of load/store transactions with a
// reactive memory model, plus hand sequences for reset and idle-noise cases.
module tb_dcache_responder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINES  = 16;
`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [1:0] M_NONE = 2'd0;
  localparam logic [1:0] M_RD   = 2'd1;
  localparam logic [1:0] M_WR   = 2'd2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              data_ready;
  logic [DATA_W-1:0] data_response;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;
  logic [2:0]        state_dbg;

  int n_vec  = 0;
  int n_fail = 0;

  dcache_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .data_ready(data_ready), .data_response(data_response), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              wr;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    int                gnt_dly;
    bit                gap;
    bit                noise;
    logic [3:0][31:0]  beats;
    logic [31:0]       exp_resp;
    logic [1:0]        exp_mem;
    logic [31:0]       exp_maddr;
    logic [31:0]       exp_hits;
    logic [31:0]       exp_misses;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int gnt_dly, input bit gap, input bit noise,
                              input logic [3:0][31:0] beats, input logic [31:0] exp_resp,
                              input logic [1:0] exp_mem, input logic [31:0] exp_maddr,
                              input logic [31:0] exp_hits, input logic [31:0] exp_misses);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.gnt_dly = gnt_dly; v.gap = gap;
    v.noise = noise; v.beats = beats; v.exp_resp = exp_resp; v.exp_mem = exp_mem;
    v.exp_maddr = exp_maddr; v.exp_hits = exp_hits; v.exp_misses = exp_misses;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request and plays the memory side until the response retires.
  task automatic run_txn(input vec_t v, input int id);
    int cyc = 0, trig = 0, rdy_cyc = -1, n_rdy = 0, n_gnt = 0;
    int req_cyc = 0, first_req = -1, wait_cnt = 0, beat = 0;
    bit granted = 0, gapped = 0, done = 0;
    logic cap_we = 1'b0;
    logic [31:0] cap_addr = '0, cap_wdata = '0, resp = '0;
    string tag;
    tag = $sformatf("v%0d", id);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    while (!done) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (data_ready) begin
        n_rdy++;
        if (rdy_cyc < 0) begin rdy_cyc = cyc; resp = data_response; end
      end
      if (mem_req) begin
        req_cyc++;
        if (first_req < 0) first_req = cyc;
      end
      if (mem_req && !granted) begin
        if (wait_cnt == v.gnt_dly) begin
          mem_gnt = 1'b1; granted = 1; n_gnt++;
          cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
          if (mem_we) trig = cyc;
        end else begin
          wait_cnt++;
          if (v.noise) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0000 + cyc; end
        end
      end else if (granted && !cap_we && beat < 4) begin
        if (v.gap && !gapped && beat == 2) gapped = 1;
        else begin
          mem_rvalid = 1'b1; mem_rdata = v.beats[beat]; beat++;
          if (beat == 4) trig = cyc;
        end
      end
      if (rdy_cyc >= 0 && cyc == rdy_cyc + 1) req_valid = 1'b0;
      if (rdy_cyc >= 0 && cyc == rdy_cyc + 3) done = 1;
      if (cyc >= 200) begin req_valid = 1'b0; done = 1; end
    end
    chk({tag, " completed"}, {31'b0, rdy_cyc >= 0}, 32'd1);
    chk({tag, " response"}, resp, v.exp_resp);
    chk({tag, " ready latency"}, rdy_cyc, trig + 1);
    chk({tag, " ready pulses"}, n_rdy, 32'd1);
    chk({tag, " mem_req cycles"}, req_cyc, (v.exp_mem != M_NONE) ? v.gnt_dly + 1 : 0);
    chk({tag, " mem grants"}, n_gnt, (v.exp_mem != M_NONE) ? 32'd1 : 32'd0);
    if (v.exp_mem != M_NONE) begin
      chk({tag, " mem_req rise"}, first_req, 32'd1);
      chk({tag, " mem_we"}, {31'b0, cap_we}, (v.exp_mem == M_WR) ? 32'd1 : 32'd0);
      chk({tag, " mem_addr"}, cap_addr, v.exp_maddr);
    end
    if (v.exp_mem == M_WR) chk({tag, " mem_wdata"}, cap_wdata, v.wdata);
    chk({tag, " hit_count"}, hit_count, STATS ? v.exp_hits : 32'd0);
    chk({tag, " miss_count"}, miss_count, STATS ? v.exp_misses : 32'd0);
  endtask

  localparam logic [3:0][31:0] BA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [3:0][31:0] BB = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [3:0][31:0] BC = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
  localparam logic [3:0][31:0] BD = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
  localparam logic [3:0][31:0] BE = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
  localparam logic [3:0][31:0] BF = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
  localparam logic [3:0][31:0] BZ = '0;

  vec_t vecs [12];
  vec_t post [3];

  initial begin
    vecs[0]  = mk(0, 32'h104,  0,            3, 0, 1, BA, 32'hA1,       M_RD,   32'h100,  0, 1);
    vecs[1]  = mk(0, 32'h10C,  0,            0, 0, 0, BZ, 32'hA3,       M_NONE, 0,        1, 1);
    vecs[2]  = mk(1, 32'h108,  32'h55,       0, 0, 0, BZ, 32'h55,       M_WR,   32'h108,  1, 1);
    vecs[3]  = mk(0, 32'h108,  0,            0, 0, 0, BZ, 32'h55,       M_NONE, 0,        2, 1);
    vecs[4]  = mk(1, 32'h2000, 32'h77,       1, 0, 0, BZ, 32'h77,       M_WR,   32'h2000, 2, 1);
    vecs[5]  = mk(0, 32'h2000, 0,            2, 1, 0, BB, 32'hB0,       M_RD,   32'h2000, 2, 2);
    vecs[6]  = mk(0, 32'h1104, 0,            0, 0, 0, BC, 32'hC1,       M_RD,   32'h1100, 2, 3);
    vecs[7]  = mk(0, 32'h104,  0,            1, 0, 0, BA, 32'hA1,       M_RD,   32'h100,  2, 4);
    vecs[8]  = mk(0, 32'h303C, 0,            2, 1, 1, BD, 32'hD3,       M_RD,   32'h3030, 2, 5);
    vecs[9]  = mk(0, 32'h3030, 0,            0, 0, 0, BZ, 32'hD0,       M_NONE, 0,        3, 5);
    vecs[10] = mk(1, 32'h3034, 32'h12345678, 0, 0, 0, BZ, 32'h12345678, M_WR,   32'h3034, 3, 5);
    vecs[11] = mk(0, 32'h3034, 0,            0, 0, 0, BZ, 32'h12345678, M_NONE, 0,        4, 5);
    post[0]  = mk(0, 32'h4044, 0,            0, 0, 0, BE, 32'hE1,       M_RD,   32'h4040, 0, 1);
    post[1]  = mk(0, 32'h303C, 0,            1, 0, 0, BF, 32'hF3,       M_RD,   32'h3030, 0, 2);
    post[2]  = mk(0, 32'h4048, 0,            0, 0, 0, BZ, 32'hE2,       M_NONE, 0,        1, 2);

    // Reset state
    #1;
    chk("reset data_ready", {31'b0, data_ready}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset data_response", data_response, 32'd0);
    chk("reset state", {29'b0, state_dbg}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Grant and read beats with no request in flight
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("idle noise busy", {31'b0, busy}, 32'd0);
    chk("idle noise mem_req", {31'b0, mem_req}, 32'd0);
    chk("idle noise ready", {31'b0, data_ready}, 32'd0);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_txn(vecs[i], i);

    // Reset asserted after two fill beats of a miss
    begin
      int w = 0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4044;
      do begin @(negedge clk); w++; end while (!mem_req && w < 20);
      chk("midfill mem_req seen", {31'b0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hE0;
      @(negedge clk);
      mem_rdata = 32'hE1;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = '0;
      chk("midfill state", {29'b0, state_dbg}, 32'd2);
      #2 reset = 1'b0; req_valid = 1'b0;
      #1;
      chk("midfill rst mem_req", {31'b0, mem_req}, 32'd0);
      chk("midfill rst busy", {31'b0, busy}, 32'd0);
      chk("midfill rst ready", {31'b0, data_ready}, 32'd0);
      chk("midfill rst mem_addr", mem_addr, 32'd0);
      chk("midfill rst data_response", data_response, 32'd0);
      chk("midfill rst state", {29'b0, state_dbg}, 32'd0);
      chk("midfill rst hit_count", hit_count, 32'd0);
      chk("midfill rst miss_count", miss_count, 32'd0);
      w = 0;
      repeat (3) begin @(negedge clk); if (data_ready) w++; end
      chk("midfill no ready", w, 32'd0);
      reset = 1'b1;
    end

    for (int i = 0; i < 3; i++) run_txn(post[i], 100 + i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
